// File: rtl/laser_fire_scheduler.sv
// laser_fire_scheduler: round-robin sharing of one laser emitter
// between NUM_REQ active-low triggers, with FIRE then COOLDOWN windows.
// Optional feature macro: LASER_REQ_SYNC_EN (2-flop input synchronizers).
module laser_fire_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int CNT_W      = 32,
    parameter int ON_CYCLES  = 100000000,
    parameter int OFF_CYCLES = 100000000
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [NUM_REQ-1:0] req_n,
    input  logic               arm,
    output logic               laser_on,
    output logic [NUM_REQ-1:0] grant,
    output logic [2:0]         owner_idx,
    output logic               busy,
    output logic               fire_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        COOL = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);
    localparam logic [3:0]       N4       = 4'(NUM_REQ);

    // request/arm as seen by the scheduler
    logic [NUM_REQ-1:0] req_act;
    logic               arm_act;

`ifdef LASER_REQ_SYNC_EN
    logic [NUM_REQ-1:0] req_s1_q;
    logic [NUM_REQ-1:0] req_s2_q;
    logic               arm_s1_q;
    logic               arm_s2_q;

    // two-stage synchronizers; idle values mean "no request, disarmed"
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            req_s1_q <= '1;
            req_s2_q <= '1;
            arm_s1_q <= 1'b0;
            arm_s2_q <= 1'b0;
        end else begin
            req_s1_q <= req_n;
            req_s2_q <= req_s1_q;
            arm_s1_q <= arm;
            arm_s2_q <= arm_s1_q;
        end
    end

    assign req_act = ~req_s2_q;
    assign arm_act = arm_s2_q;
`else
    assign req_act = ~req_n;
    assign arm_act = arm;
`endif

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               laser_q, laser_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [2:0]         owner_q, owner_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [2:0]         ptr_q, ptr_d;

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic                 win_vld;
    logic [3:0]           win_sum;
    logic [3:0]           nxt_sum;
    logic [2:0]           win_idx;
    logic [2:0]           win_nxt;

    // round-robin pick: first active request at or above the pointer
    always_comb begin
        req_dbl = {req_act, req_act};
        req_rot = NUM_REQ'(req_dbl >> ptr_q);
        win_vld = 1'b0;
        win_sum = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_vld && req_rot[k]) begin
                win_vld = 1'b1;
                win_sum = {1'b0, ptr_q} + 4'(k);
            end
        end
        if (win_sum >= N4) begin
            win_sum = win_sum - N4;
        end
        win_idx = win_sum[2:0];
        nxt_sum = win_sum + 4'd1;
        if (nxt_sum == N4) begin
            nxt_sum = '0;
        end
        win_nxt = nxt_sum[2:0];
    end

    // next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        laser_d = laser_q;
        grant_d = grant_q;
        owner_d = owner_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (arm_act && win_vld) begin
                    state_d = FIRE;
                    cnt_d   = '0;
                    laser_d = 1'b1;
                    grant_d = NUM_REQ'(1) << win_idx;
                    owner_d = win_idx;
                    busy_d  = 1'b1;
                    ptr_d   = win_nxt;
                    done_d  = (ON_LAST == '0);
                end
            end
            FIRE: begin
                if (cnt_q == ON_LAST) begin
                    state_d = COOL;
                    cnt_d   = '0;
                    laser_d = 1'b0;
                    grant_d = '0;
                end else if (!arm_act) begin
                    // abort: the shot ends here, done marks the cut-off
                    state_d = COOL;
                    cnt_d   = '0;
                    laser_d = 1'b0;
                    grant_d = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    done_d = ((cnt_q + CNT_W'(1)) == ON_LAST);
                end
            end
            COOL: begin
                if (cnt_q == OFF_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                laser_d = 1'b0;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // state and output registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            laser_q <= 1'b0;
            grant_q <= '0;
            owner_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            laser_q <= laser_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ptr_q   <= ptr_d;
        end
    end

    assign laser_on  = laser_q;
    assign grant     = grant_q;
    assign owner_idx = owner_q;
    assign busy      = busy_q;
    assign fire_done = done_q;

endmodule

// File: tb/tb_laser_fire_scheduler.sv
// tb_laser_fire_scheduler: directed and random checks of the shared
// laser scheduler against a remaining-time behavioural model.
module tb_laser_fire_scheduler;

    localparam int N   = 4;
    localparam int ON  = 4;
    localparam int OFF = 3;
    localparam int CW  = 32;
`ifdef LASER_REQ_SYNC_EN
    localparam int LAT     = 3;
    localparam int ABT_LEN = 4;
`else
    localparam int LAT     = 1;
    localparam int ABT_LEN = 2;
`endif

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic [N-1:0] req_n = '1;
    logic         arm = 1'b1;
    logic         laser_on;
    logic [N-1:0] grant;
    logic [2:0]   owner_idx;
    logic         busy;
    logic         fire_done;

    laser_fire_scheduler #(
        .NUM_REQ(N), .CNT_W(CW), .ON_CYCLES(ON), .OFF_CYCLES(OFF)
    ) dut (
        .clock(clk), .resetn(resetn), .req_n(req_n), .arm(arm),
        .laser_on(laser_on), .grant(grant), .owner_idx(owner_idx),
        .busy(busy), .fire_done(fire_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // model: laser cycles left, cooldown cycles left, owner, pointer
    int           m_fire = 0;
    int           m_cool = 0;
    int           m_owner = 0;
    int           m_ptr = 0;
    int           m_c = 0;
    bit           m_done = 0;
    logic [N-1:0] m_req;
    logic         m_arm;
    logic [N-1:0] p_req0 = '1, p_req1 = '1;
    logic         p_arm0 = 1'b0, p_arm1 = 1'b0;

    task automatic model_reset();
        m_fire = 0; m_cool = 0; m_owner = 0; m_ptr = 0; m_done = 0;
        p_req0 = '1; p_req1 = '1; p_arm0 = 1'b0; p_arm1 = 1'b0;
    endtask

    task automatic model_step();
`ifdef LASER_REQ_SYNC_EN
        m_req = p_req1; m_arm = p_arm1;
        p_req1 = p_req0; p_arm1 = p_arm0;
        p_req0 = req_n; p_arm0 = arm;
`else
        m_req = req_n; m_arm = arm;
`endif
        m_done = 0;
        if (m_fire > 0) begin
            if (m_fire == 1) begin
                m_fire = 0; m_cool = OFF;
            end else if (!m_arm) begin
                m_fire = 0; m_cool = OFF; m_done = 1;
            end else begin
                m_fire--; m_done = (m_fire == 1);
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (m_arm && m_req != '1) begin
            for (int k = 0; k < N; k++) begin
                m_c = (m_ptr + k) % N;
                if (!m_req[m_c]) begin
                    m_owner = m_c;
                    break;
                end
            end
            m_ptr = (m_owner + 1) % N;
            m_fire = ON;
            m_done = (ON == 1);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) model_reset();
            else model_step();
        end
    end

    // per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            chk("laser_on", laser_on, m_fire > 0);
            chk("grant", grant, m_fire > 0 ? (32'd1 << m_owner) : 32'd0);
            chk("owner_idx", owner_idx, m_owner);
            chk("busy", busy, (m_fire > 0) || (m_cool > 0));
            chk("fire_done", fire_done, m_done);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        req_n = '1; arm = 1'b1;
        step();
        resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;
        step();
    endtask

    task automatic wait_laser(input logic v, input string nm);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (laser_on !== v && k < 60);
        chk(nm, laser_on, v);
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (busy !== 1'b0 && k < 60);
        chk(nm, busy, 0);
    endtask

    int owners[$];
    int onr[$];
    int offr[$];
    int run, n, done_at, on_cnt, done_cnt, cool_cnt;
    logic prev;
    int exp_own[5] = '{0, 1, 2, 3, 0};

    initial begin
        repeat (2) @(posedge clk);
        #2 resetn = 1'b1;
        @(negedge clk);
        chk("rst_laser", laser_on, 0);
        chk("rst_grant", grant, 0);
        chk("rst_owner", owner_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", fire_done, 0);

        // single short request from player 2
        do_reset();
        req_n = 4'b1011;
        step();
        req_n = '1;
        wait_laser(1'b1, "t1_rise");
        chk("t1_grant", grant, 4'b0100);
        chk("t1_owner", owner_idx, 2);
        n = 0; done_at = -1;
        while (laser_on && n < 20) begin
            if (fire_done) done_at = n;
            n++;
            @(negedge clk);
        end
        chk("t1_on_len", n, ON);
        chk("t1_done_pos", done_at, ON - 1);
        n = 0;
        while (busy && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("t1_cool_len", n, OFF);
        chk("t1_owner_kept", owner_idx, 2);

        // continuous full load rotates owners
        do_reset();
        req_n = 4'b0000;
        prev = 1'b0; run = 0;
        repeat (44) begin
            @(negedge clk);
            if (laser_on != prev) begin
                if (prev) onr.push_back(run);
                else if (owners.size() > 0) offr.push_back(run);
                run = 0;
                if (laser_on) owners.push_back(int'(owner_idx));
            end
            run++;
            prev = laser_on;
        end
        req_n = '1;
        chk("t2_shots", owners.size() >= 5 && onr.size() >= 5
            && offr.size() >= 4, 1);
        for (int i = 0; i < 5 && i < owners.size(); i++)
            chk("t2_owner", owners[i], exp_own[i]);
        for (int i = 0; i < 5 && i < onr.size(); i++)
            chk("t2_on_len", onr[i], ON);
        for (int i = 0; i < 4 && i < offr.size(); i++)
            chk("t2_gap", offr[i], OFF + 1);

        // request only during cooldown is dropped
        do_reset();
        req_n = 4'b1110;
        step();
        req_n = '1;
        wait_laser(1'b1, "t3_rise");
        wait_laser(1'b0, "t3_fall");
        req_n = 4'b1101;
        step();
        req_n = '1;
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (laser_on) n++;
        end
        chk("t3_no_grant", n, 0);
        chk("t3_owner", owner_idx, 0);

        // abort on second FIRE cycle, then stay disarmed
        do_reset();
        req_n = 4'b1110;
        step();
        wait_laser(1'b1, "t4_rise");
        on_cnt = 1; done_cnt = fire_done; cool_cnt = 0;
        step();
        arm = 1'b0;
        repeat (20) begin
            @(negedge clk);
            on_cnt += laser_on;
            done_cnt += fire_done;
            cool_cnt += (busy && !laser_on);
        end
        chk("t4_on_len", on_cnt, ABT_LEN);
        chk("t4_done_cnt", done_cnt, 1);
        chk("t4_cool_len", cool_cnt, OFF);
        chk("t4_idle", busy, 0);
        arm = 1'b1;
        req_n = '1;

        // asynchronous reset mid-FIRE
        do_reset();
        req_n = 4'b1101;
        step();
        req_n = '1;
        wait_laser(1'b1, "t5_rise");
        step();
        resetn = 1'b0;
        #1;
        chk("t5_async_laser", laser_on, 0);
        chk("t5_async_grant", grant, 0);
        chk("t5_async_busy", busy, 0);
        step();
        resetn = 1'b1;
        req_n = 4'b0111;
        wait_laser(1'b1, "t5_rise2");
        chk("t5_grant3", grant, 4'b1000);
        chk("t5_owner3", owner_idx, 3);
        req_n = '1;
        wait_idle("t5_idle");

        // pointer restarts at 0 after reset
        do_reset();
        req_n = 4'b1101;
        step();
        req_n = '1;
        wait_laser(1'b1, "t5b_rise");
        step();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        req_n = 4'b0101;
        wait_laser(1'b1, "t5b_rise2");
        chk("t5b_owner", owner_idx, 1);
        req_n = '1;

        // request-to-laser latency
        do_reset();
        req_n = 4'b1110;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!laser_on && n < 10);
        chk("t6_latency", n, LAT);
        req_n = '1;
        wait_idle("t6_idle");

        // random traffic against the model
        do_reset();
        for (int i = 0; i < 700; i++) begin
            step();
            if ($urandom_range(0, 2) == 0) begin
                for (int b = 0; b < N; b++)
                    req_n[b] = ($urandom_range(0, 3) != 0);
                arm = ($urandom_range(0, 9) != 0);
            end
            if ($urandom_range(0, 249) == 0) begin
                resetn = 1'b0;
                step();
                resetn = 1'b1;
            end
        end
        req_n = '1;
        arm = 1'b1;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
